// File: rtl/fp_dot_accum_if.sv
// Handshake bundle between the product stream, the job controller and the
// tile writeback consumer of fp_dot_accum.
// master: the side that issues jobs, feeds products and consumes results.
// slave: the accumulator itself.
interface fp_dot_accum_if #(
  parameter int LEN_W = 8
);

  // Job request channel
  logic [LEN_W-1:0] start_len;
  logic             start_valid;
  logic             start_ready;

  // Product stream from the Q2.14 multiplier
  logic [15:0]      prod;
  logic             prod_valid;
  logic             prod_ready;

  // Result channel towards writeback
  logic [15:0]      dot;
  logic             dot_valid;
  logic             dot_ready;
  logic             overflow;

  modport master (
    output start_len, start_valid, prod, prod_valid, dot_ready,
    input  start_ready, prod_ready, dot, dot_valid, overflow
  );

  modport slave (
    input  start_len, start_valid, prod, prod_valid, dot_ready,
    output start_ready, prod_ready, dot, dot_valid, overflow
  );

endinterface

// File: rtl/fp_dot_accum.sv
// Fixed-point dot-product accumulator.
// Sums a programmed number of signed Q2.14 products in an ACC_W-bit
// accumulator and returns one Q2.14 result per job with an overflow flag.
// ACC_W must be at least 16 + LEN_W so the running sum can never wrap.
// Optional feature macro: FP_DOT_ACCUM_SATURATE_EN
//   defined   -> out-of-range results clamp to 0x7FFF / 0x8000
//   undefined -> the result is the low 16 bits of the sum (wrap)
// The overflow flag is produced the same way in both builds.
module fp_dot_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic           CLK,
  input logic           RST_N,
  fp_dot_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        dot_q, dot_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic [LEN_W-1:0]   cnt_inc;
  logic               last_term;
  logic [ACC_W-16:0]  sum_upper;
  logic               sum_ovf;
  logic [15:0]        sum_dot;

  // Next running sum and its Q2.14 conversion, used when the final term lands
  always_comb begin
    prod_ext  = {{(ACC_W-16){bus.prod[15]}}, bus.prod};
    acc_sum   = acc_q + prod_ext;
    cnt_inc   = cnt_q + LEN_W'(1);
    last_term = (cnt_inc == len_q);
    sum_upper = acc_sum[ACC_W-1:15];
    sum_ovf   = !((&sum_upper) || !(|sum_upper));
`ifdef FP_DOT_ACCUM_SATURATE_EN
    if (sum_ovf) begin
      sum_dot = acc_sum[ACC_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      sum_dot = acc_sum[15:0];
    end
`else
    sum_dot = acc_sum[15:0];
`endif
  end

  // Job sequencing: accept a job, accumulate its terms, hold the result
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dot_d   = dot_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          len_d = bus.start_len;
          acc_d = '0;
          cnt_d = '0;
          if (bus.start_len == '0) begin
            dot_d   = 16'h0000;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (bus.prod_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (last_term) begin
            dot_d   = sum_dot;
            ovf_d   = sum_ovf;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.dot_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dot_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dot_q   <= dot_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.prod_ready  = (state_q == ACCUM);
  assign bus.dot_valid   = (state_q == DONE);
  assign bus.dot         = dot_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/fp_dot_accum.md
# fp_dot_accum

Fixed-point dot-product accumulator sitting directly downstream of the 16-bit Q2.14 multiplier in the MMM datapath. It consumes a stream of signed Q2.14 products and sums a run-time-programmed number of them in a widened accumulator. It presents one Q2.14 result per job over a valid/ready handshake, together with an overflow flag, for the matrix-tile writeback stage.

## Interface
- `ACC_W`, 24: accumulator width in bits; must be ≥ 16 + `LEN_W`.
- `LEN_W`, 8: width of the term-count field; max terms per job is 2^`LEN_W` − 1.
- `CLK`  in  1: single clock; all state updates on rising edge.
- `RST_N`  in  1: reset, synchronous, active-low.
- `start_len`  in  `LEN_W`: number of products in the job; sampled on the start handshake.
- `start_valid`  in  1: job request.
- `start_ready`  out  1: block can accept a job; high only in IDLE.
- `prod`  in  16: signed Q2.14 product from the multiplier.
- `prod_valid`  in  1: `prod` is valid.
- `prod_ready`  out  1: block accepts a product; high only in ACCUM.
- `dot`  out  16: signed Q2.14 result.
- `dot_valid`  out  1: `dot`/`overflow` valid; high only in DONE.
- `dot_ready`  in  1: consumer accepts the result.
- `overflow`  out  1: result did not fit in Q2.14; valid with `dot_valid`.

## Operation
- States: IDLE, ACCUM, DONE.
- A handshake on any channel means valid and ready both high at a rising edge.
- IDLE to ACCUM: on the start handshake with `start_len` ≠ 0.
  - Latch `start_len`; clear the accumulator and the term counter.
- IDLE to DONE: on the start handshake with `start_len` = 0.
  - Result is 0 with `overflow` = 0.
- ACCUM, each product handshake:
  - Sign-extend `prod` to `ACC_W` and add it to the accumulator.
  - Increment the counter.
  - The handshake that completes the final term moves the state to DONE.
- ACCUM with `prod_valid` low: hold state; no accumulation.
- DONE:
  - `dot` and `overflow` are registered and stable until the result handshake.
  - On the result handshake, go to IDLE.
- Inputs on a channel whose ready is low are ignored: `start_valid` outside IDLE, `prod_valid` outside ACCUM.
- Accumulator arithmetic is exact by construction (width rule on `ACC_W`); it never wraps internally.
- Result conversion from the accumulator (Q(`ACC_W`−14).14) to Q2.14 happens once, on entry to DONE.
  - `overflow` = 1 iff accumulator bits [`ACC_W`−1:15] are not all equal, i.e. the value lies outside [−32768, 32767] LSBs.
  - The conversion rule for `dot` is set by the macro in Configuration.
- Reset while `RST_N` = 0 at an edge, in any state (including mid-job):
  - State IDLE; accumulator, counter, `dot` and `overflow` cleared.
  - The partial job is discarded with no result emitted.

## Timing
- Reset values: `start_ready` = 1, `prod_ready` = 0, `dot_valid` = 0, `dot` = 0x0000, `overflow` = 0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Start accepted at edge t: `prod_ready` = 1 from cycle t+1, or `dot_valid` = 1 from t+1 when len = 0.
- Throughput: one product per cycle with no bubbles.
- Latency: last product accepted at edge t → `dot_valid` = 1 during cycle t+1.
- Result accepted at edge t → `start_ready` = 1 during t+1.
  - Minimum gap between jobs is one IDLE cycle.
- Back-pressure: with `dot_ready` low, the block stays in DONE indefinitely with `dot` unchanged, `prod_ready` = 0 and `start_ready` = 0.

## Configuration
- `FP_DOT_ACCUM_SATURATE_EN` defined:
  - On overflow, `dot` clamps to 0x7FFF (positive) or 0x8000 (negative).
  - Otherwise `dot` = accumulator[15:0].
- Not defined:
  - `dot` = accumulator[15:0] always (two's-complement wrap).
  - `overflow` is still computed and reported identically.

## Test plan
- len=4, prod 0x1000 ×4 back-to-back → `dot` = 0x4000, `overflow` = 0, `dot_valid` one cycle after the fourth product handshake.
- len=3, prod 0x7000 ×3 → `overflow` = 1; `dot` = 0x7FFF with the macro defined, 0x5000 without.
- len=2, prod 0xC000 ×2 → `dot` = 0x8000, `overflow` = 0. This is the exact −2.0 boundary and must not flag.
- len=0 → `dot` = 0x0000, `overflow` = 0, `dot_valid` on the cycle after the start handshake; `prod_ready` never asserts.
- len=3 with `prod_valid` gaps, then `dot_ready` low for 3 cycles:
  - Sum is correct; `dot` is held stable throughout back-pressure.
  - `start_ready` and `prod_ready` stay 0; `start_valid` pulses during back-pressure are ignored.
- len=4, `RST_N` low for one cycle after 2 products:
  - All outputs return to reset values; no result is emitted.
  - A following len=1 job with prod 0x0123 yields `dot` = 0x0123.
